// File: rtl/rgb_to_gray_pipe.sv
// Three-stage RGB to grayscale converter with per-frame mode select (luma, average, value, green).
// One pixel per clock; stall_i freezes every stage so nothing is dropped or duplicated.
`timescale 1ns/1ps
module rgb_to_gray_pipe #(
    parameter int DATA_W = 8,
    parameter int WR     = 77,
    parameter int WG     = 150,
    parameter int WB     = 29
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] red_i,
    input  logic [DATA_W-1:0] green_i,
    input  logic [DATA_W-1:0] blue_i,
    input  logic              done_i,
    input  logic              sof_i,
    input  logic [1:0]        mode_i,
    input  logic              stall_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] grayscale_o,
    output logic              done_o,
    output logic              sof_o,
    output logic [23:0]       pix_cnt_o
);

    // Three 8-bit weighted products of DATA_W-bit channels fit in DATA_W+10 bits.
    localparam int ACC_W = DATA_W + 10;

    localparam logic [1:0] MODE_LUMA = 2'd0;
    localparam logic [1:0] MODE_AVG  = 2'd1;
    localparam logic [1:0] MODE_VAL  = 2'd2;

    localparam logic [7:0] WR_L = 8'(WR);
    localparam logic [7:0] WG_L = 8'(WG);
    localparam logic [7:0] WB_L = 8'(WB);

    localparam logic [ACC_W:0]    LUMA_MAX = {{(ACC_W + 1 - DATA_W){1'b0}}, {DATA_W{1'b1}}};
    localparam logic [DATA_W+1:0] AVG_MAX  = {2'b00, {DATA_W{1'b1}}};
    localparam logic [DATA_W+1:0] DIV3     = (DATA_W + 2)'(3);

    logic              en;
    logic              accept;
    logic [1:0]        mode_reg;
    logic [1:0]        mode_next;

    logic              s1_valid;
    logic              s1_sof;
    logic [1:0]        s1_mode;
    logic [DATA_W-1:0] s1_red;
    logic [DATA_W-1:0] s1_green;
    logic [DATA_W-1:0] s1_blue;

    logic [ACC_W-1:0]  luma_sum;
    logic [DATA_W+1:0] avg_sum;
    logic [DATA_W-1:0] max_rg;
    logic [DATA_W-1:0] max_rgb;
    logic [ACC_W-1:0]  acc_next;

    logic              s2_valid;
    logic              s2_sof;
    logic [1:0]        s2_mode;
    logic [ACC_W-1:0]  s2_acc;

    logic [ACC_W:0]    luma_rnd;
    logic [ACC_W:0]    luma_shift;
    logic [DATA_W+1:0] avg_q;
    logic [DATA_W-1:0] gray_next;

    assign en      = ~stall_i;
    assign ready_o = ~stall_i;
    assign accept  = done_i & en;

    // The sof pixel itself already uses the freshly loaded mode.
    assign mode_next = (accept && sof_i) ? mode_i : mode_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg <= MODE_LUMA;
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_mode  <= MODE_LUMA;
            s1_red   <= '0;
            s1_green <= '0;
            s1_blue  <= '0;
        end else if (en) begin
            s1_valid <= done_i;
            if (accept) begin
                mode_reg <= mode_next;
                s1_sof   <= sof_i;
                s1_mode  <= mode_next;
                s1_red   <= red_i;
                s1_green <= green_i;
                s1_blue  <= blue_i;
            end
        end
    end

    assign luma_sum = ACC_W'(s1_red) * ACC_W'(WR_L)
                    + ACC_W'(s1_green) * ACC_W'(WG_L)
                    + ACC_W'(s1_blue) * ACC_W'(WB_L);
    assign avg_sum  = {2'b00, s1_red} + {2'b00, s1_green} + {2'b00, s1_blue};
    assign max_rg   = (s1_red > s1_green) ? s1_red : s1_green;
    assign max_rgb  = (max_rg > s1_blue) ? max_rg : s1_blue;

    always_comb begin
        acc_next = '0;
        case (s1_mode)
            MODE_LUMA: acc_next = luma_sum;
            MODE_AVG:  acc_next = ACC_W'(avg_sum);
            MODE_VAL:  acc_next = ACC_W'(max_rgb);
            default:   acc_next = ACC_W'(s1_green);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sof   <= 1'b0;
            s2_mode  <= MODE_LUMA;
            s2_acc   <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_sof   <= s1_sof;
            s2_mode  <= s1_mode;
            s2_acc   <= acc_next;
        end
    end

    assign luma_rnd   = {1'b0, s2_acc} + (ACC_W + 1)'(128);
    assign luma_shift = luma_rnd >> 8;
    assign avg_q      = s2_acc[DATA_W+1:0] / DIV3;

    always_comb begin
        gray_next = '0;
        case (s2_mode)
            MODE_LUMA: gray_next = (luma_shift > LUMA_MAX) ? {DATA_W{1'b1}} : luma_shift[DATA_W-1:0];
            MODE_AVG:  gray_next = (avg_q > AVG_MAX) ? {DATA_W{1'b1}} : avg_q[DATA_W-1:0];
            default:   gray_next = s2_acc[DATA_W-1:0];
        endcase
    end

    // Bubbles leave the last sample and the count untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_o      <= 1'b0;
            sof_o       <= 1'b0;
            grayscale_o <= '0;
            pix_cnt_o   <= '0;
        end else if (en) begin
            done_o <= s2_valid;
            sof_o  <= s2_valid & s2_sof;
            if (s2_valid) begin
                grayscale_o <= gray_next;
                pix_cnt_o   <= s2_sof ? 24'd1 : pix_cnt_o + 24'd1;
            end
        end
    end

endmodule

// File: tb/tb_rgb_to_gray_pipe.sv
// Directed bench for rgb_to_gray_pipe: vector table plus reset, stall and width/saturation sequences.
`timescale 1ns/1ps
module tb_rgb_to_gray_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [11:0] r12 = '0, g12 = '0, b12 = '0;
    logic        done_i = 1'b0, sof_i = 1'b0, stall_i = 1'b0;
    logic [1:0]  mode_i = 2'd0;

    logic [7:0]  r8, g8, b8;
    assign r8 = r12[7:0];
    assign g8 = g12[7:0];
    assign b8 = b12[7:0];

    logic        ready_o, done_o, sof_o;
    logic [7:0]  gray_o;
    logic [23:0] cnt_o;

    logic        s_ready, s_done, s_sof;
    logic [7:0]  s_gray;
    logic [23:0] s_cnt;

    logic        w_ready, w_done, w_sof;
    logic [11:0] w_gray;
    logic [23:0] w_cnt;

    rgb_to_gray_pipe dut (
        .clk(clk), .rst(rst), .red_i(r8), .green_i(g8), .blue_i(b8),
        .done_i(done_i), .sof_i(sof_i), .mode_i(mode_i), .stall_i(stall_i),
        .ready_o(ready_o), .grayscale_o(gray_o), .done_o(done_o), .sof_o(sof_o),
        .pix_cnt_o(cnt_o)
    );

    rgb_to_gray_pipe #(.DATA_W(8), .WR(200), .WG(200), .WB(200)) u_sat (
        .clk(clk), .rst(rst), .red_i(r8), .green_i(g8), .blue_i(b8),
        .done_i(done_i), .sof_i(sof_i), .mode_i(mode_i), .stall_i(stall_i),
        .ready_o(s_ready), .grayscale_o(s_gray), .done_o(s_done), .sof_o(s_sof),
        .pix_cnt_o(s_cnt)
    );

    rgb_to_gray_pipe #(.DATA_W(12)) u_wide (
        .clk(clk), .rst(rst), .red_i(r12), .green_i(g12), .blue_i(b12),
        .done_i(done_i), .sof_i(sof_i), .mode_i(mode_i), .stall_i(stall_i),
        .ready_o(w_ready), .grayscale_o(w_gray), .done_o(w_done), .sof_o(w_sof),
        .pix_cnt_o(w_cnt)
    );

    typedef struct {
        logic [11:0] r, g, b;
        logic        vld, sof;
        logic [1:0]  mode;
        logic [7:0]  exp;
        logic [23:0] cnt;
        logic        sat_chk, wide_chk;
        logic [11:0] wide_exp;
    } vec_t;

    typedef struct {
        logic [7:0]  gray;
        logic [23:0] cnt;
        logic        sof;
        int          due;
        logic        sat_chk, wide_chk;
        logic [11:0] wide_exp;
    } exp_t;

    exp_t q[$];
    vec_t tab[19];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic stall_q = 1'b0, rst_q = 1'b1;

    function automatic vec_t mk(int r, int g, int b, bit vld, bit sof, int mode,
                                int exp, int cnt, bit sc, bit wc, int we);
        vec_t v;
        v.r = 12'(r); v.g = 12'(g); v.b = 12'(b);
        v.vld = vld; v.sof = sof; v.mode = 2'(mode);
        v.exp = 8'(exp); v.cnt = 24'(cnt);
        v.sat_chk = sc; v.wide_chk = wc; v.wide_exp = 12'(we);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v, input logic stall, input bit push, input bit lat);
        exp_t e;
        r12 = v.r; g12 = v.g; b12 = v.b;
        done_i = v.vld; sof_i = v.sof; mode_i = v.mode; stall_i = stall;
        if (push && v.vld && !stall) begin
            e.gray = v.exp; e.cnt = v.cnt; e.sof = v.sof;
            e.due = lat ? cyc + 3 : -1;
            e.sat_chk = v.sat_chk; e.wide_chk = v.wide_chk; e.wide_exp = v.wide_exp;
            q.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0);
    endtask

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        stall_q <= stall_i;
        rst_q   <= rst;
    end

    logic [7:0]  p_gray;
    logic [23:0] p_cnt;
    logic        p_done, p_sof;
    logic        p_ok = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (p_ok && stall_q && !rst_q) begin
                check("freeze_gray", gray_o, p_gray);
                check("freeze_done", done_o, p_done);
                check("freeze_sof", sof_o, p_sof);
                check("freeze_cnt", cnt_o, p_cnt);
            end
            if (done_o && !stall_i) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done actual=1 required=0 gray=%0d", gray_o);
                end else begin
                    e = q.pop_front();
                    check("gray", gray_o, e.gray);
                    check("sof_o", sof_o, e.sof);
                    check("pix_cnt", cnt_o, e.cnt);
                    if (e.due >= 0) check("latency", cyc, e.due);
                    if (e.sat_chk) check("sat_gray", s_gray, 255);
                    if (e.wide_chk) check("wide_gray", w_gray, e.wide_exp);
                end
            end
        end
        p_gray <= gray_o; p_done <= done_o; p_sof <= sof_o; p_cnt <= cnt_o;
        p_ok   <= 1'b1;
    end

    initial begin
        int idx;
        logic st;
        tab[0]  = mk(255,   0,   0, 1, 1, 0,  77, 1, 0, 0, 0);
        tab[1]  = mk(  0, 255,   0, 1, 0, 0, 149, 2, 0, 0, 0);
        tab[2]  = mk(  0,   0,   0, 0, 0, 0,   0, 0, 0, 0, 0);
        tab[3]  = mk(  0,   0, 255, 1, 0, 0,  29, 3, 0, 0, 0);
        tab[4]  = mk(255, 255, 255, 1, 0, 0, 255, 4, 1, 0, 0);
        tab[5]  = mk( 10, 200,  31, 1, 1, 1,  80, 1, 0, 0, 0);
        tab[6]  = mk( 10, 200,  31, 1, 1, 2, 200, 1, 0, 0, 0);
        tab[7]  = mk( 10, 200,  31, 1, 1, 3, 200, 1, 0, 0, 0);
        tab[8]  = mk( 10, 200,  31, 1, 1, 0, 124, 1, 0, 0, 0);
        tab[9]  = mk(100,  50,  20, 1, 1, 1,  56, 1, 0, 0, 0);
        tab[10] = mk(100,  50,  20, 1, 0, 2,  56, 2, 0, 0, 0);
        tab[11] = mk(100,  50,  20, 1, 0, 3,  56, 3, 0, 0, 0);
        tab[12] = mk(100,  50,  20, 1, 1, 2, 100, 1, 0, 0, 0);
        tab[13] = mk(100,  50,  20, 1, 0, 0, 100, 2, 0, 0, 0);
        tab[14] = mk(100,  50,  20, 1, 0, 1, 100, 3, 0, 0, 0);
        tab[15] = mk(4095, 4095, 4094, 1, 1, 1, 254, 1, 0, 1, 4094);
        tab[16] = mk(4095, 4095, 4095, 1, 1, 0, 255, 1, 1, 1, 4095);
        tab[17] = mk(  0,   0,   2, 1, 1, 1,   0, 1, 0, 0, 0);
        tab[18] = mk(  1,   1,   2, 1, 0, 3,   1, 2, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("rst_done", done_o, 0);
        check("rst_gray", gray_o, 0);
        check("rst_sof", sof_o, 0);
        check("rst_cnt", cnt_o, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_done", done_o, 0);

        for (int i = 0; i < 19; i++) drive(tab[i], 1'b0, 1'b1, 1'b1);
        idle(6);
        check("drain_table", q.size(), 0);

        // Reset with pixels in flight; mode was 1 before reset and must return to 0.
        drive(mk(100, 50, 20, 1, 1, 1, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0);
        drive(mk(100, 50, 20, 1, 0, 1, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        drive(mk(100, 50, 20, 1, 0, 1, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0);
        check("midrst_done", done_o, 0);
        check("midrst_gray", gray_o, 0);
        check("midrst_cnt", cnt_o, 0);
        idle(1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check("flush_done", done_o, 0);
        end
        drive(mk(10, 200, 31, 1, 0, 2, 124, 1, 0, 0, 0), 1'b0, 1'b1, 1'b1);
        idle(6);
        check("drain_reset", q.size(), 0);

        // Continuous green-mode stream with a 4-cycle stall in the middle.
        idx = 0;
        for (int k = 0; k < 20 && idx < 8; k++) begin
            st = (k >= 3 && k <= 6);
            drive(mk(0, idx + 1, 0, 1, idx == 0, 3, idx + 1, idx + 1, 0, 0, 0), st, 1'b1, 1'b0);
            check("ready", ready_o, !st);
            if (!st) idx++;
        end
        idle(8);
        check("drain_stall", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
